// File: rtl/lpc_post_fifo_if.sv
// Decoded LPC back-end bus between the LPC peripheral state machine (master)
// and an I/O target such as the POST code FIFO (slave).
interface lpc_post_fifo_if;
    logic        lpc_en;
    logic [15:0] lpc_addr;
    logic        io_rden_sm;
    logic        io_wren_sm;
    logic [7:0]  lpc_data_in;
    logic        addr_hit;
    logic [7:0]  din;

    modport master (
        output lpc_en,
        output lpc_addr,
        output io_rden_sm,
        output io_wren_sm,
        output lpc_data_in,
        input  addr_hit,
        input  din
    );

    modport slave (
        input  lpc_en,
        input  lpc_addr,
        input  io_rden_sm,
        input  io_wren_sm,
        input  lpc_data_in,
        output addr_hit,
        output din
    );
endinterface

// File: rtl/lpc_post_fifo.sv
// BIOS POST code capture: port 0x80 writes land in a FIFO and in last_code;
// the host drains the FIFO and reads a status byte through two I/O read ports.
module lpc_post_fifo #(
    parameter logic [15:0] POST_ADDR  = 16'h0080,
    parameter logic [15:0] STAT_ADDR  = 16'h0084,
    parameter logic [15:0] DATA_ADDR  = 16'h0085,
    parameter int          DEPTH_LOG2 = 4
) (
    input  logic                  lclk,
    input  logic                  lreset_n,
    lpc_post_fifo_if.slave        bus,
    input  logic                  clear,
    output logic [7:0]            last_code,
    output logic                  code_strobe,
    output logic [DEPTH_LOG2:0]   fifo_count,
    output logic                  overflow
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  wr_req;
    logic                  rd_req;
    logic                  wr_req_q;
    logic                  rd_req_q;
    logic                  wr_edge;
    logic                  rd_edge;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic                  stat_rd;
    logic                  data_rd;
    logic                  bad_rd;
    logic [7:0]            status;

    assign wr_req = bus.lpc_en & bus.io_wren_sm & (bus.lpc_addr == POST_ADDR);
    assign rd_req = bus.lpc_en & bus.io_rden_sm;

    assign bus.addr_hit = wr_req |
                          (rd_req & ((bus.lpc_addr == STAT_ADDR) | (bus.lpc_addr == DATA_ADDR)));

    // The peripheral holds its strobes for several cycles; act once per transaction.
    assign wr_edge = wr_req & ~wr_req_q;
    assign rd_edge = rd_req & ~rd_req_q;

    assign full  = (fifo_count == CNT_FULL);
    assign empty = (fifo_count == '0);

    // A read colliding with a write edge is answered with 0xFF and never pops.
    assign stat_rd = rd_edge & ~wr_edge & (bus.lpc_addr == STAT_ADDR);
    assign data_rd = rd_edge & ~wr_edge & (bus.lpc_addr == DATA_ADDR);
    assign bad_rd  = rd_edge & wr_edge &
                     ((bus.lpc_addr == STAT_ADDR) | (bus.lpc_addr == DATA_ADDR));

    assign push = wr_edge & ~full & ~clear;
    assign pop  = data_rd & ~empty & ~clear;

    assign status = {overflow, full, empty, 5'(fifo_count)};

    always_ff @(posedge lclk) begin
        if (push) begin
            mem[wr_ptr] <= bus.lpc_data_in;
        end
    end

    always_ff @(posedge lclk) begin
        if (!lreset_n) begin
            wr_req_q    <= 1'b0;
            rd_req_q    <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            last_code   <= 8'h00;
            code_strobe <= 1'b0;
            overflow    <= 1'b0;
            bus.din     <= 8'hFF;
        end else begin
            wr_req_q    <= wr_req;
            rd_req_q    <= rd_req;
            code_strobe <= wr_edge;

            if (wr_edge) begin
                last_code <= bus.lpc_data_in;
            end

            if (bad_rd) begin
                bus.din <= 8'hFF;
            end else if (data_rd) begin
                bus.din <= empty ? 8'hFF : mem[rd_ptr];
            end else if (stat_rd) begin
                bus.din <= status;
            end

            // Clear outranks everything so a coincident push is discarded.
            if (clear) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                fifo_count <= '0;
            end else if (push) begin
                wr_ptr     <= wr_ptr + PTR_ONE;
                fifo_count <= fifo_count + CNT_ONE;
            end else if (pop) begin
                rd_ptr     <= rd_ptr + PTR_ONE;
                fifo_count <= fifo_count - CNT_ONE;
            end

            if (clear) begin
                overflow <= 1'b0;
            end else if (wr_edge & full) begin
                overflow <= 1'b1;
            end else if (stat_rd) begin
                overflow <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_lpc_post_fifo.sv
// Scoreboard bench for lpc_post_fifo: a queue model of the FIFO predicts read
// data, which is queued at stimulus time and compared when din settles.
module tb_lpc_post_fifo;
    localparam logic [15:0] POST_ADDR = 16'h0080;
    localparam logic [15:0] STAT_ADDR = 16'h0084;
    localparam logic [15:0] DATA_ADDR = 16'h0085;
    localparam int          DEPTH     = 16;

    logic       lclk;
    logic       lreset_n;
    logic       clear;
    logic [7:0] last_code;
    logic       code_strobe;
    logic [4:0] fifo_count;
    logic       overflow;

    lpc_post_fifo_if bus ();

    lpc_post_fifo #(
        .POST_ADDR  (POST_ADDR),
        .STAT_ADDR  (STAT_ADDR),
        .DATA_ADDR  (DATA_ADDR),
        .DEPTH_LOG2 (4)
    ) dut (
        .lclk        (lclk),
        .lreset_n    (lreset_n),
        .bus         (bus),
        .clear       (clear),
        .last_code   (last_code),
        .code_strobe (code_strobe),
        .fifo_count  (fifo_count),
        .overflow    (overflow)
    );

    initial lclk = 1'b0;
    always #5 lclk = ~lclk;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] model_q [$];
    logic [7:0] exp_q [$];
    logic [7:0] model_din;
    logic [7:0] model_last;
    logic       model_ovf;

    task automatic check_output(input string tag, input logic [15:0] actual, input logic [15:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic check_state();
        check_output("fifo_count", 16'(fifo_count), 16'(model_q.size()));
        check_output("overflow", 16'(overflow), 16'(model_ovf));
        check_output("last_code", 16'(last_code), 16'(model_last));
    endtask

    task automatic bus_idle();
        bus.lpc_en      = 1'b0;
        bus.lpc_addr    = 16'h0000;
        bus.io_rden_sm  = 1'b0;
        bus.io_wren_sm  = 1'b0;
        bus.lpc_data_in = 8'h00;
    endtask

    task automatic model_reset();
        model_q.delete();
        exp_q.delete();
        model_din  = 8'hFF;
        model_last = 8'h00;
        model_ovf  = 1'b0;
    endtask

    task automatic apply_write(input logic [15:0] addr, input logic [7:0] data, input logic with_clear);
        int strobes;
        logic hit;
        strobes = 0;
        hit = (addr == POST_ADDR);
        @(posedge lclk); #1;
        bus.lpc_en      = 1'b1;
        bus.lpc_addr    = addr;
        bus.io_wren_sm  = 1'b1;
        bus.lpc_data_in = data;
        clear           = with_clear;
        for (int c = 0; c < 4; c++) begin
            @(negedge lclk);
            check_output("addr_hit_wr", 16'(bus.addr_hit), 16'(hit));
            if (code_strobe) strobes++;
            @(posedge lclk); #1;
            clear = 1'b0;
        end
        bus_idle();
        for (int c = 0; c < 2; c++) begin
            @(negedge lclk);
            if (code_strobe) strobes++;
        end
        if (hit) model_last = data;
        if (with_clear) begin
            model_q.delete();
            model_ovf = 1'b0;
        end else if (hit) begin
            if (model_q.size() < DEPTH) model_q.push_back(data);
            else model_ovf = 1'b1;
        end
        check_output("strobe_count", 16'(strobes), hit ? 16'd1 : 16'd0);
        check_state();
    endtask

    task automatic predict_read(input logic [15:0] addr);
        logic [7:0] exp;
        if (addr == DATA_ADDR) begin
            exp = (model_q.size() != 0) ? model_q.pop_front() : 8'hFF;
        end else if (addr == STAT_ADDR) begin
            exp = {model_ovf, model_q.size() == DEPTH, model_q.size() == 0, 5'(model_q.size())};
            model_ovf = 1'b0;
        end else begin
            exp = model_din;
        end
        model_din = exp;
        exp_q.push_back(exp);
    endtask

    task automatic apply_read(input logic [15:0] addr);
        logic hit;
        hit = (addr == STAT_ADDR) || (addr == DATA_ADDR);
        predict_read(addr);
        @(posedge lclk); #1;
        bus.lpc_en     = 1'b1;
        bus.lpc_addr   = addr;
        bus.io_rden_sm = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge lclk);
            check_output("addr_hit_rd", 16'(bus.addr_hit), 16'(hit));
            @(posedge lclk); #1;
        end
        bus_idle();
        @(negedge lclk);
        check_output("din", 16'(bus.din), 16'(exp_q.pop_front()));
        check_state();
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus_idle();
        clear    = 1'b0;
        lreset_n = 1'b0;
        model_reset();
        repeat (2) @(posedge lclk);
        #1 lreset_n = 1'b1;
        @(negedge lclk);
        check_output("rst_din", 16'(bus.din), 16'h00FF);
        check_output("rst_strobe", 16'(code_strobe), 16'd0);
        check_state();

        // Single POST code; held write strobe must push only once.
        apply_write(POST_ADDR, 8'hA5, 1'b0);
        apply_read(DATA_ADDR);

        // Fill to full and overflow, then status snapshot clears overflow.
        for (int i = 1; i <= 17; i++) apply_write(POST_ADDR, 8'(i), 1'b0);
        apply_read(STAT_ADDR);
        apply_read(STAT_ADDR);

        // Drain past empty.
        for (int i = 0; i < 17; i++) apply_read(DATA_ADDR);
        apply_read(STAT_ADDR);

        // Non-decoded addresses are ignored.
        apply_write(16'h0081, 8'h77, 1'b0);
        apply_read(POST_ADDR);
        apply_read(16'h0081);

        // Clear coincident with a push.
        for (int i = 0; i < 3; i++) apply_write(POST_ADDR, 8'(8'h30 + i), 1'b0);
        apply_write(POST_ADDR, 8'h5A, 1'b1);
        apply_read(STAT_ADDR);

        // Reset in the middle of a data read.
        apply_write(POST_ADDR, 8'h21, 1'b0);
        apply_write(POST_ADDR, 8'h22, 1'b0);
        predict_read(DATA_ADDR);
        @(posedge lclk); #1;
        bus.lpc_en     = 1'b1;
        bus.lpc_addr   = DATA_ADDR;
        bus.io_rden_sm = 1'b1;
        @(posedge lclk); #1;
        lreset_n = 1'b0;
        @(posedge lclk); #1;
        lreset_n = 1'b1;
        model_reset();
        exp_q.push_back(8'hFF);
        repeat (2) @(posedge lclk);
        #1 bus_idle();
        @(negedge lclk);
        check_output("rst_mid_din", 16'(bus.din), 16'(exp_q.pop_front()));
        check_state();
        model_din = 8'hFF;

        apply_write(POST_ADDR, 8'hC3, 1'b0);
        apply_read(DATA_ADDR);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
